// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, arbitrates exception/mispredict flushes,
// holds exception flushes behind outstanding data-bus traffic, counts stall cycles.
module pipe_ctrl #(
    parameter int EXC_WAIT_MAX = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             mem_busy_i,
    input  logic             exception_i,
    input  logic [31:0]      exc_new_pc_i,
    input  logic             bpu_fail_i,
    input  logic [31:0]      bpu_target_i,
    output logic [3:0]       stall_o,
    output logic             flush_o,
    output logic             flush_cause_o,
    output logic [31:0]      new_pc_o,
    output logic             exc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] EXC_WAIT  = 2'd1;
    localparam logic [1:0] EXC_FLUSH = 2'd2;
    localparam int WW = $clog2(EXC_WAIT_MAX + 1);

    logic [1:0]    state, state_n;
    logic [31:0]   exc_pc;
    logic [WW-1:0] wait_cnt;
    logic          wait_last;
    logic          exc_hold;

    assign wait_last = wait_cnt == WW'(EXC_WAIT_MAX - 1);
    assign exc_hold  = state == RUN && exception_i && mem_busy_i;

    always_comb begin
        stall_o       = 4'b0000;
        flush_o       = 1'b0;
        flush_cause_o = 1'b0;
        new_pc_o      = 32'h0;
        state_n       = state;
        case (state)
            RUN: begin
                if (exception_i && mem_busy_i) begin
                    stall_o = 4'b1111;
                    state_n = EXC_WAIT;
                end else if (exception_i) begin
                    flush_o  = 1'b1;
                    new_pc_o = exc_new_pc_i;
                end else if (bpu_fail_i && !stallreq_mem_i && !stallreq_ex_i) begin
                    flush_o       = 1'b1;
                    flush_cause_o = 1'b1;
                    new_pc_o      = bpu_target_i;
                end else begin
                    stall_o = stallreq_mem_i ? 4'b0111 :
                              stallreq_ex_i  ? 4'b0011 :
                              stallreq_id_i  ? 4'b0001 : 4'b0000;
                end
            end
            EXC_WAIT: begin
                stall_o = 4'b1111;
                state_n = (!mem_busy_i || wait_last) ? EXC_FLUSH : EXC_WAIT;
            end
            EXC_FLUSH: begin
                flush_o  = 1'b1;
                new_pc_o = exc_pc;
                state_n  = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= RUN;
            exc_pc        <= 32'h0;
            wait_cnt      <= '0;
            exc_timeout_o <= 1'b0;
            stall_cnt_o   <= '0;
        end else begin
            state <= state_n;
            if (exc_hold) begin
                exc_pc   <= exc_new_pc_i;
                wait_cnt <= '0;
            end else if (state == EXC_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // timeout only when the bus is still busy at the last allowed wait cycle
            if (state == EXC_WAIT && mem_busy_i && wait_last)
                exc_timeout_o <= 1'b1;
            if (|stall_o)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random stimulus checked against a cycle-level
// behavioural model of the pipeline controller.
module tb_pipe_ctrl;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stallreq_id_i = 1'b0, stallreq_ex_i = 1'b0, stallreq_mem_i = 1'b0;
    logic        mem_busy_i = 1'b0, exception_i = 1'b0, bpu_fail_i = 1'b0;
    logic [31:0] exc_new_pc_i = 32'h0, bpu_target_i = 32'h0;
    logic [3:0]  stall_o;
    logic        flush_o, flush_cause_o, exc_timeout_o;
    logic [31:0] new_pc_o, stall_cnt_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_WAIT_MAX(MAXW), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .stallreq_id_i(stallreq_id_i), .stallreq_ex_i(stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i), .mem_busy_i(mem_busy_i),
        .exception_i(exception_i), .exc_new_pc_i(exc_new_pc_i),
        .bpu_fail_i(bpu_fail_i), .bpu_target_i(bpu_target_i),
        .stall_o(stall_o), .flush_o(flush_o), .flush_cause_o(flush_cause_o),
        .new_pc_o(new_pc_o), .exc_timeout_o(exc_timeout_o), .stall_cnt_o(stall_cnt_o)
    );

    int checks = 0, passed = 0, fails = 0;

    // model: waiting = exception parked behind the bus, pending = flush due this cycle
    bit          m_waiting, m_pending, m_timeout;
    int          m_waited;
    logic [31:0] m_pc, m_cnt;
    logic [3:0]  e_stall;
    logic        e_flush, e_cause;
    logic [31:0] e_pc;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_pending = 0; m_timeout = 0; m_waited = 0;
        m_pc = 32'h0; m_cnt = 32'h0;
    endtask

    task automatic eval();
        e_stall = 4'b0000; e_flush = 0; e_cause = 0; e_pc = 32'h0;
        if (m_pending) begin
            e_flush = 1; e_pc = m_pc;
        end else if (m_waiting) begin
            e_stall = 4'b1111;
        end else if (exception_i) begin
            if (mem_busy_i) e_stall = 4'b1111;
            else begin e_flush = 1; e_pc = exc_new_pc_i; end
        end else if (bpu_fail_i && !stallreq_mem_i && !stallreq_ex_i) begin
            e_flush = 1; e_cause = 1; e_pc = bpu_target_i;
        end else if (stallreq_mem_i) e_stall = 4'b0111;
        else if (stallreq_ex_i) e_stall = 4'b0011;
        else if (stallreq_id_i) e_stall = 4'b0001;
    endtask

    task automatic tick();
        #2;
        eval();
        check("stall", 32'(stall_o), 32'(e_stall));
        check("flush", 32'(flush_o), 32'(e_flush));
        if (e_flush) begin
            check("cause", 32'(flush_cause_o), 32'(e_cause));
            check("new_pc", new_pc_o, e_pc);
        end
        @(posedge clk);
        if (e_stall != 0) m_cnt = m_cnt + 1;
        if (m_pending) m_pending = 0;
        else if (m_waiting) begin
            m_waited++;
            if (!mem_busy_i) begin m_waiting = 0; m_pending = 1; end
            else if (m_waited == MAXW) begin m_timeout = 1; m_waiting = 0; m_pending = 1; end
        end else if (exception_i && mem_busy_i) begin
            m_waiting = 1; m_waited = 0; m_pc = exc_new_pc_i;
        end
        #1;
        check("stall_cnt", stall_cnt_o, m_cnt);
        check("timeout", 32'(exc_timeout_o), 32'(m_timeout));
    endtask

    task automatic drive(logic id, logic ex, logic mem, logic busy, logic exc,
                         logic [31:0] epc, logic bpu, logic [31:0] tgt);
        stallreq_id_i = id; stallreq_ex_i = ex; stallreq_mem_i = mem; mem_busy_i = busy;
        exception_i = exc; exc_new_pc_i = epc; bpu_fail_i = bpu; bpu_target_i = tgt;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        do_reset();
        #2;
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_flush", 32'(flush_o), 32'h0);
        check("rst_cause", 32'(flush_cause_o), 32'h0);
        check("rst_pc", new_pc_o, 32'h0);
        check("rst_timeout", 32'(exc_timeout_o), 32'h0);
        check("rst_cnt", stall_cnt_o, 32'h0);
        @(posedge clk); #1;
        // load-use stall for three cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        // mispredict held while EX frozen, then released
        drive(0, 1, 0, 0, 0, 0, 1, 32'hBFC0_0380);
        repeat (2) tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
        tick();
        drive(0, 0, 0, 0, 1, 32'hBFC0_0380, 1, 32'h1234_5678);
        tick();
        // exception parked behind five busy cycles
        drive(0, 0, 0, 1, 1, 32'h8000_0180, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (4) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        // bus stuck busy: forced flush and sticky timeout
        drive(0, 0, 0, 1, 1, 32'h8000_0200, 1, 32'hDEAD_BEEF);
        tick();
        drive(0, 1, 1, 1, 1, 32'h1111_1111, 1, 32'h2222_2222);
        repeat (MAXW + 2) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        // reset in the middle of a wait: no flush afterwards
        drive(0, 0, 0, 1, 1, 32'h8000_0300, 0, 0);
        repeat (3) tick();
        do_reset();
        tick();
        tick();
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) == 0, $urandom);
            tick();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
